// File: rtl/sqrt_pipe_tagged_pkg.sv
// Shared types and constants for the tagged square-root pipeline.
// The tagged direction records travel unchanged beside the radicand.
package sqrt_pipe_tagged_pkg;

  localparam int SQ_WIDTH  = 16;  // default data width of x_in and len
  localparam int SQ_Q_BITS = 8;   // default fractional bits
  localparam int TAG_SIZE  = 64;  // tag field width
  localparam int DIR_WIDTH = 16;  // width of each direction component

  typedef struct packed {
    logic [TAG_SIZE-1:0]  tag;
    logic [DIR_WIDTH-1:0] dir_x;
    logic [DIR_WIDTH-1:0] dir_y;
    logic [DIR_WIDTH-1:0] dir_z;
  } TaggedDirection;

  typedef struct packed {
    logic [TAG_SIZE-1:0]  tag;
    logic [DIR_WIDTH-1:0] dir_x;
    logic [DIR_WIDTH-1:0] dir_y;
    logic [DIR_WIDTH-1:0] dir_z;
    logic [SQ_WIDTH-1:0]  len;
  } TaggedDirection_len;

  // Number of pipeline stages needed to cover n iterations, ips per stage.
  function automatic int stage_count(input int n, input int ips);
    return (n + ips - 1) / ips;
  endfunction

endpackage

// File: rtl/sqrt_pipe_tagged_iter_stage.sv
// One registered slice of the digit-by-digit square root.
// Runs ITERS restoring iterations starting at iteration START, then
// registers remainder, partial root, radicand, tag payload, neg flag, valid.
module sqrt_iter_stage
  import sqrt_pipe_tagged_pkg::*;
#(
  parameter int RAD_W = 24,
  parameter int ITERS = 1,
  parameter int START = 0,
  localparam int ROOT_W = RAD_W / 2,
  localparam int REM_W  = ROOT_W + 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                in_valid,
  input  logic                in_neg,
  input  logic [RAD_W-1:0]    in_rad,
  input  logic [REM_W-1:0]    in_rem,
  input  logic [ROOT_W-1:0]   in_root,
  input  TaggedDirection      in_td,
  output logic                out_valid,
  output logic                out_neg,
  output logic [RAD_W-1:0]    out_rad,
  output logic [REM_W-1:0]    out_rem,
  output logic [ROOT_W-1:0]   out_root,
  output TaggedDirection      out_td
);

  logic [REM_W-1:0]  rem_next;
  logic [ROOT_W-1:0] root_next;
  logic [RAD_W-1:0]  rad_v;
  logic [REM_W-1:0]  trial_v;

  logic              valid_reg;
  logic              neg_reg;
  logic [RAD_W-1:0]  rad_reg;
  logic [REM_W-1:0]  rem_reg;
  logic [ROOT_W-1:0] root_reg;
  TaggedDirection    td_reg;

  // Restoring iterations: bring down the next radicand bit pair, try to
  // subtract 4*root+1, and shift the resulting root bit in.
  always_comb begin
    rem_next  = in_rem;
    root_next = in_root;
    rad_v     = in_rad << (2 * START);
    trial_v   = '0;
    for (int j = 0; j < ITERS; j++) begin
      rem_next = (rem_next << 2) | REM_W'(rad_v[RAD_W-1 -: 2]);
      rad_v    = rad_v << 2;
      trial_v  = (REM_W'(root_next) << 2) | REM_W'(1);
      if (rem_next >= trial_v) begin
        rem_next  = rem_next - trial_v;
        root_next = (root_next << 1) | ROOT_W'(1);
      end else begin
        root_next = root_next << 1;
      end
    end
  end

  // Stage register: holds while the pipeline is stalled, clears on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      neg_reg   <= 1'b0;
      rad_reg   <= '0;
      rem_reg   <= '0;
      root_reg  <= '0;
      td_reg    <= '0;
    end else if (en) begin
      valid_reg <= in_valid;
      neg_reg   <= in_neg;
      rad_reg   <= in_rad;
      rem_reg   <= rem_next;
      root_reg  <= root_next;
      td_reg    <= in_td;
    end
  end

  assign out_valid = valid_reg;
  assign out_neg   = neg_reg;
  assign out_rad   = rad_reg;
  assign out_rem   = rem_reg;
  assign out_root  = root_reg;
  assign out_td    = td_reg;

endmodule

// File: rtl/sqrt_pipe_tagged.sv
// Pipelined fixed-point square root carrying a TaggedDirection payload in
// lock-step, with valid/ready flow control and an in-flight counter.
// The last stage register doubles as the output register.
module sqrt_pipe_tagged
  import sqrt_pipe_tagged_pkg::*;
#(
  parameter int WIDTH           = SQ_WIDTH,
  parameter int Q_BITS          = SQ_Q_BITS,
  parameter int ITERS_PER_STAGE = 1,
  localparam int N      = (WIDTH + Q_BITS) / 2,
  localparam int STAGES = stage_count(N, ITERS_PER_STAGE),
  localparam int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x_in,
  input  TaggedDirection     TD_in,
  output logic               out_valid,
  input  logic               out_ready,
  output TaggedDirection_len TDL_out,
  output logic               neg_err,
  output logic               busy,
  output logic [CNT_W-1:0]   in_flight
);

  localparam int RAD_W = WIDTH + Q_BITS;
  localparam int REM_W = N + 3;

  logic en;
  logic accept;
  logic consume;

  logic             valid_s [0:STAGES];
  logic             neg_s   [0:STAGES];
  logic [RAD_W-1:0] rad_s   [0:STAGES];
  logic [REM_W-1:0] rem_s   [0:STAGES];
  logic [N-1:0]     root_s  [0:STAGES];
  TaggedDirection   td_s    [0:STAGES];

  logic [CNT_W-1:0] in_flight_reg;
  logic [CNT_W-1:0] in_flight_next;

  // The whole pipe advances unless a valid output is being refused.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign consume  = out_valid && out_ready;

  // Negative radicands are forced to zero so the root comes out as 0.
  assign valid_s[0] = in_valid;
  assign neg_s[0]   = x_in[WIDTH-1];
  assign rad_s[0]   = x_in[WIDTH-1] ? '0 : {x_in, {Q_BITS{1'b0}}};
  assign rem_s[0]   = '0;
  assign root_s[0]  = '0;
  assign td_s[0]    = TD_in;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int ITERS_I =
        ((gi == STAGES - 1) && (N % ITERS_PER_STAGE != 0)) ? (N % ITERS_PER_STAGE)
                                                           : ITERS_PER_STAGE;
      sqrt_iter_stage #(
        .RAD_W (RAD_W),
        .ITERS (ITERS_I),
        .START (gi * ITERS_PER_STAGE)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (valid_s[gi]),
        .in_neg    (neg_s[gi]),
        .in_rad    (rad_s[gi]),
        .in_rem    (rem_s[gi]),
        .in_root   (root_s[gi]),
        .in_td     (td_s[gi]),
        .out_valid (valid_s[gi+1]),
        .out_neg   (neg_s[gi+1]),
        .out_rad   (rad_s[gi+1]),
        .out_rem   (rem_s[gi+1]),
        .out_root  (root_s[gi+1]),
        .out_td    (td_s[gi+1])
      );
    end
  endgenerate

  // Output record: payload from the last stage, root zero-extended to len.
  always_comb begin
    TDL_out       = '0;
    TDL_out.tag   = td_s[STAGES].tag;
    TDL_out.dir_x = td_s[STAGES].dir_x;
    TDL_out.dir_y = td_s[STAGES].dir_y;
    TDL_out.dir_z = td_s[STAGES].dir_z;
    TDL_out.len   = SQ_WIDTH'(root_s[STAGES]);
  end

  assign out_valid = valid_s[STAGES];
  assign neg_err   = neg_s[STAGES];

  // Occupancy: +1 on accept, -1 on consume, unchanged when both happen.
  always_comb begin
    in_flight_next = in_flight_reg;
    case ({accept, consume})
      2'b10:   in_flight_next = in_flight_reg + CNT_W'(1);
      2'b01:   in_flight_next = in_flight_reg - CNT_W'(1);
      default: in_flight_next = in_flight_reg;
    endcase
  end

  // Occupancy register; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_flight_reg <= '0;
    end else begin
      in_flight_reg <= in_flight_next;
    end
  end

  assign in_flight = in_flight_reg;
  assign busy      = (in_flight_reg != '0);

endmodule

// File: tb/tb_sqrt_pipe_tagged.sv
// Bench for sqrt_pipe_tagged: one instance with 1 iteration per stage and
// one with 5, a floor(sqrt) reference model with in-order scoreboards,
// a table of known vectors, and sequences for stall, latency and reset.
module tb_sqrt_pipe_tagged;
  import sqrt_pipe_tagged_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic               iv1, ir1, ov1, or1, neg1, busy1;
  logic [15:0]        x1;
  TaggedDirection     td1;
  TaggedDirection_len tdl1;
  logic [3:0]         fl1;

  logic               iv5, ir5, ov5, or5, neg5, busy5;
  logic [15:0]        x5;
  TaggedDirection     td5;
  TaggedDirection_len tdl5;
  logic [1:0]         fl5;

  sqrt_pipe_tagged #(.WIDTH(16), .Q_BITS(8), .ITERS_PER_STAGE(1)) dut1 (
    .clk(clk), .reset(reset_n), .in_valid(iv1), .in_ready(ir1), .x_in(x1),
    .TD_in(td1), .out_valid(ov1), .out_ready(or1), .TDL_out(tdl1),
    .neg_err(neg1), .busy(busy1), .in_flight(fl1));

  sqrt_pipe_tagged #(.WIDTH(16), .Q_BITS(8), .ITERS_PER_STAGE(5)) dut5 (
    .clk(clk), .reset(reset_n), .in_valid(iv5), .in_ready(ir5), .x_in(x5),
    .TD_in(td5), .out_valid(ov5), .out_ready(or5), .TDL_out(tdl5),
    .neg_err(neg5), .busy(busy5), .in_flight(fl5));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0]    x;
    TaggedDirection td;
  } txn_t;

  txn_t q1[$];
  txn_t q5[$];
  txn_t e1, e5;
  int seen1 = 0;
  int seen5 = 0;
  int peak1 = 0;

  typedef struct {
    logic [15:0] x;
    logic [63:0] tag;
    logic [15:0] len;
    logic        neg;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  // Reference: len = floor(sqrt(x * 2^8)) for non-negative x, else 0.
  function automatic logic [15:0] ref_len(input logic [15:0] x);
    longint r_val, rt;
    if (x[15]) return 16'h0000;
    r_val = longint'(x) * 256;
    rt = longint'($sqrt(real'(r_val)));
    while (rt * rt > r_val) rt--;
    while ((rt + 1) * (rt + 1) <= r_val) rt++;
    return 16'(rt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 1-iteration instance: check consumes, record accepts.
  always @(negedge clk) begin
    if (!reset_n) begin
      q1.delete();
    end else begin
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL d1_unexpected: got tag %0h, want no output", tdl1.tag);
        end else begin
          e1 = q1.pop_front();
          check("d1_len", 128'(tdl1.len), 128'(ref_len(e1.x)));
          check("d1_payload", 128'({tdl1.tag, tdl1.dir_x, tdl1.dir_y, tdl1.dir_z}), 128'(e1.td));
          check("d1_neg", 128'(neg1), 128'(e1.x[15]));
          seen1++;
          $display("d1 out #%0d x=%04h tag=%0h len=%04h neg=%0b", seen1, e1.x, tdl1.tag, tdl1.len, neg1);
        end
      end
      if (iv1 && ir1) q1.push_back('{x1, td1});
      if (int'(fl1) > peak1) peak1 = int'(fl1);
    end
  end

  // Scoreboard for the 5-iteration instance.
  always @(negedge clk) begin
    if (!reset_n) begin
      q5.delete();
    end else begin
      if (ov5 && or5) begin
        if (q5.size() == 0) begin
          total++;
          bad++;
          $display("FAIL d5_unexpected: got tag %0h, want no output", tdl5.tag);
        end else begin
          e5 = q5.pop_front();
          check("d5_len", 128'(tdl5.len), 128'(ref_len(e5.x)));
          check("d5_payload", 128'({tdl5.tag, tdl5.dir_x, tdl5.dir_y, tdl5.dir_z}), 128'(e5.td));
          check("d5_neg", 128'(neg5), 128'(e5.x[15]));
          seen5++;
          $display("d5 out #%0d x=%04h tag=%0h len=%04h neg=%0b", seen5, e5.x, tdl5.tag, tdl5.len, neg5);
        end
      end
      if (iv5 && ir5) q5.push_back('{x5, td5});
    end
  end

  task automatic run_burst(input int lo, input int hi, input int exp_peak);
    int n;
    peak1 = 0;
    for (int i = lo; i <= hi; i++) begin
      x1 = tbl[i].x;
      td1 = '0;
      td1.tag = tbl[i].tag;
      td1.dir_x = 16'(i);
      iv1 = 1'b1;
      tick();
    end
    iv1 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = lo; i <= hi; i++) begin
      check("tbl_valid", 128'(ov1), 128'(1));
      check("tbl_len", 128'(tdl1.len), 128'(tbl[i].len));
      check("tbl_tag", 128'(tdl1.tag), 128'(tbl[i].tag));
      check("tbl_neg", 128'(neg1), 128'(tbl[i].neg));
      @(negedge clk);
    end
    check("tbl_peak_in_flight", 128'(peak1), 128'(exp_peak));
    tick();
  endtask

  task automatic drain1();
    int n = 0;
    while ((q1.size() != 0 || busy1) && n < 500) begin
      tick();
      n++;
    end
    check("d1_drained", 128'(q1.size()), 128'(0));
  endtask

  task automatic drain5();
    int n = 0;
    while ((q5.size() != 0 || busy5) && n < 500) begin
      tick();
      n++;
    end
    check("d5_drained", 128'(q5.size()), 128'(0));
  endtask

  task automatic send1(input logic [15:0] x, input logic [63:0] tag);
    logic acc;
    int n = 0;
    x1 = x;
    td1 = '0;
    td1.tag = tag;
    td1.dir_y = 16'($urandom);
    iv1 = 1'b1;
    do begin
      @(negedge clk);
      acc = ir1;
      tick();
      n++;
    end while (!acc && n < 100);
    iv1 = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL d1_send_timeout: got no accept, want accept");
    end
  endtask

  // Driver process
  initial begin
    int lat, n, start_seen, acc5;
    logic done5;
    TaggedDirection_len held;

    tbl[0] = '{16'h0200, 64'hA0, 16'h016A, 1'b0};
    tbl[1] = '{16'h7FFF, 64'hA1, 16'h0B50, 1'b0};
    tbl[2] = '{16'h0000, 64'hA2, 16'h0000, 1'b0};
    tbl[3] = '{16'h0001, 64'hA3, 16'h0010, 1'b0};
    tbl[4] = '{16'h8000, 64'h22, 16'h0000, 1'b1};
    tbl[5] = '{16'h0400, 64'hA5, 16'h0200, 1'b0};

    reset_n = 1'b0;
    iv1 = 1'b0; or1 = 1'b1; x1 = '0; td1 = '0;
    iv5 = 1'b0; or5 = 1'b1; x5 = '0; td5 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 128'(ov1), 128'(0));
    check("rst_in_flight", 128'(fl1), 128'(0));
    check("rst_busy", 128'(busy1), 128'(0));
    check("rst_tdl_out", 128'(tdl1), 128'(0));
    check("rst_neg_err", 128'(neg1), 128'(0));
    check("rst5_out_valid", 128'(ov5), 128'(0));
    check("rst5_in_flight", 128'(fl5), 128'(0));
    tick();
    reset_n = 1'b1;
    tick();

    // Single 4.0 through 12 stages: output appears 12 edges after presentation.
    x1 = 16'h0400; td1 = '0; td1.tag = 64'h11; iv1 = 1'b1; lat = 0;
    do begin
      tick();
      iv1 = 1'b0;
      lat++;
      @(negedge clk);
    end while (!ov1 && lat < 40);
    check("d1_latency", 128'(lat), 128'(12));
    check("d1_single_len", 128'(tdl1.len), 128'(16'h0200));
    check("d1_single_tag", 128'(tdl1.tag), 128'(64'h11));
    check("d1_single_neg", 128'(neg1), 128'(0));
    tick();

    // Known vectors: a 4-deep burst, then a negative followed by a normal one.
    run_burst(0, 3, 4);
    run_burst(4, 5, 2);

    // Backpressure: 20 inputs with a 5-cycle out_ready=0 window mid-stream.
    start_seen = seen1;
    peak1 = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) send1(16'($urandom_range(16'h7FFF)), {32'hB0B0, 32'(i)});
      end
      begin
        n = 0;
        do begin
          tick();
          n++;
        end while (!ov1 && n < 100);
        or1 = 1'b0;
        held = tdl1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_in_ready", 128'(ir1), 128'(0));
          check("stall_tdl_stable", 128'(tdl1), 128'(held));
          check("stall_in_flight_max", 128'(int'(fl1) <= 12), 128'(1));
          tick();
        end
        or1 = 1'b1;
      end
    join
    drain1();
    check("bp_outputs", 128'(seen1 - start_seen), 128'(20));
    check("bp_peak_le_12", 128'(peak1 <= 12), 128'(1));
    check("bp_peak_full", 128'(peak1), 128'(12));

    // Five iterations per stage: three stages of latency.
    x5 = 16'h0400; td5 = '0; td5.tag = 64'h55; iv5 = 1'b1; lat = 0;
    do begin
      tick();
      iv5 = 1'b0;
      lat++;
      @(negedge clk);
    end while (!ov5 && lat < 40);
    check("d5_latency", 128'(lat), 128'(3));
    check("d5_single_len", 128'(tdl5.len), 128'(16'h0200));
    check("d5_single_tag", 128'(tdl5.tag), 128'(64'h55));
    tick();

    // Reset with 6 entries in flight, then confirm clean restart.
    for (int i = 0; i < 6; i++) begin
      x1 = 16'($urandom_range(16'h7FFF));
      td1 = '0;
      td1.tag = 64'hDEAD_0000 + 64'(i);
      iv1 = 1'b1;
      tick();
    end
    iv1 = 1'b0;
    @(negedge clk);
    check("pre_reset_in_flight", 128'(fl1), 128'(6));
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_out_valid", 128'(ov1), 128'(0));
    check("post_reset_in_flight", 128'(fl1), 128'(0));
    check("post_reset_busy", 128'(busy1), 128'(0));
    tick();
    start_seen = seen1;
    for (int i = 0; i < 3; i++) send1(16'(16'h0100 * (i + 1)), 64'h300 + 64'(i));
    drain1();
    check("post_reset_outputs", 128'(seen1 - start_seen), 128'(3));

    // Random sweep on the 5-iteration instance with random backpressure.
    start_seen = seen5;
    acc5 = 0;
    done5 = 1'b0;
    fork
      begin
        n = 0;
        while (acc5 < 1000 && n < 20000) begin
          iv5 = ($urandom_range(3) != 0);
          x5 = 16'($urandom);
          td5.tag = {$urandom, $urandom};
          td5.dir_x = 16'($urandom);
          td5.dir_y = 16'($urandom);
          td5.dir_z = 16'($urandom);
          @(negedge clk);
          if (iv5 && ir5) acc5++;
          tick();
          n++;
        end
        iv5 = 1'b0;
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          or5 = ($urandom_range(3) != 0);
          tick();
        end
        or5 = 1'b1;
      end
    join
    drain5();
    check("sweep_accepted", 128'(acc5), 128'(1000));
    check("sweep_outputs", 128'(seen5 - start_seen), 128'(acc5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "time limit reached");
  end

endmodule
